// File: rtl/lo_gray_decoder.sv
// ---------------------------------------------------------------------------
// lo_gray_decoder
//   Resynchronises the 8-bit gray count coming from the LO ripple divider
//   (asynchronous to clk), converts it to binary phase, and checks that each
//   step is a legal +1 advance. It raises per-step strobes and a wrap pulse,
//   keeps a saturating error count, and tracks lock.
//
// Parameters
//   SYNC_STAGES : depth of the synchroniser on gray_in (2 or 3)
//   LOCK_CNT    : number of consecutive legal +1 steps needed to declare lock (1..255)
//   ERR_W       : width of the saturating step-error counter (>= 2)
//
// Ports
//   clk        in   system clock; all state changes on the rising edge
//   rstb       in   synchronous reset, active low
//   en         in   decode/check enable
//   gray_in    in   [7:0] gray count from the divider chain (async to clk)
//   bin_out    out  [7:0] registered binary phase
//   bin_valid  out  1-cycle strobe: bin_out took a new legal value
//   wrap_pulse out  1-cycle strobe: legal step 255 -> 0
//   step_err   out  1-cycle strobe: illegal step detected
//   err_count  out  [ERR_W-1:0] saturating count of step_err events
//   locked     out  lock FSM is in LOCKED
// ---------------------------------------------------------------------------
module lo_gray_decoder #(
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_CNT    = 16,
  parameter int ERR_W       = 8
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             en,
  input  logic [7:0]       gray_in,
  output logic [7:0]       bin_out,
  output logic             bin_valid,
  output logic             wrap_pulse,
  output logic             step_err,
  output logic [ERR_W-1:0] err_count,
  output logic             locked
);

  typedef enum logic {
    ST_UNLOCKED = 1'b0,
    ST_LOCKED   = 1'b1
  } state_t;

  function automatic logic [7:0] gray2bin(input logic [7:0] g);
    logic [7:0] b;
    b[7] = g[7];
    for (int i = 6; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    return (&v) ? v : v + {{(ERR_W-1){1'b0}}, 1'b1};
  endfunction

  logic [7:0]       r_sync_p0 [SYNC_STAGES];
  logic [7:0]       r_prev_p1;
  logic [7:0]       r_bin_p1;
  logic             r_primed;
  logic             r_bin_valid_p1;
  logic             r_wrap_p1;
  logic             r_step_err_p1;
  logic [ERR_W-1:0] r_err_count;
  logic [7:0]       r_run;
  state_t           r_state;

  logic [7:0] w_cur;
  logic       w_fwd;
  logic       w_hold;
  logic       w_fwd_ev;
  logic       w_ill_ev;
  logic [8:0] w_run_inc;
  logic [7:0] w_run_nxt;
  state_t     w_state_nxt;

  // ---- stage p0: synchroniser, runs regardless of en ----
  always_ff @(posedge clk) begin
    if (!rstb) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_sync_p0[i] <= '0;
    end else begin
      r_sync_p0[0] <= gray_in;
      for (int i = 1; i < SYNC_STAGES; i++) r_sync_p0[i] <= r_sync_p0[i-1];
    end
  end

  // ---- stage p1: convert, classify against previous phase, register outputs ----
  assign w_cur    = gray2bin(r_sync_p0[SYNC_STAGES-1]);
  assign w_fwd    = (w_cur == r_prev_p1 + 8'd1);
  assign w_hold   = (w_cur == r_prev_p1);
  // Only a primed, enabled cycle is classified; the priming cycle only loads prev.
  assign w_fwd_ev = en & r_primed & w_fwd;
  assign w_ill_ev = en & r_primed & ~w_fwd & ~w_hold;

  always_ff @(posedge clk) begin
    if (!rstb) begin
      r_prev_p1      <= '0;
      r_bin_p1       <= '0;
      r_primed       <= 1'b0;
      r_bin_valid_p1 <= 1'b0;
      r_wrap_p1      <= 1'b0;
      r_step_err_p1  <= 1'b0;
      r_err_count    <= '0;
    end else begin
      r_bin_valid_p1 <= 1'b0;
      r_wrap_p1      <= 1'b0;
      r_step_err_p1  <= 1'b0;
      if (!en) begin
        r_primed <= 1'b0;
      end else if (!r_primed) begin
        r_prev_p1 <= w_cur;
        r_bin_p1  <= w_cur;
        r_primed  <= 1'b1;
      end else if (w_fwd) begin
        r_prev_p1      <= w_cur;
        r_bin_p1       <= w_cur;
        r_bin_valid_p1 <= 1'b1;
        r_wrap_p1      <= (r_prev_p1 == 8'hFF);
      end else if (!w_hold) begin
        r_prev_p1     <= w_cur;
        r_bin_p1      <= w_cur;
        r_step_err_p1 <= 1'b1;
        r_err_count   <= sat_inc(r_err_count);
      end
    end
  end

  // Lock FSM: state register
  always_ff @(posedge clk) begin
    if (!rstb) begin
      r_state <= ST_UNLOCKED;
      r_run   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_run   <= w_run_nxt;
    end
  end

  // Lock FSM: next state. run only counts while unlocked; LOCKED ignores it.
  assign w_run_inc = {1'b0, r_run} + 9'd1;

  always_comb begin
    w_state_nxt = r_state;
    w_run_nxt   = r_run;
    case (r_state)
      ST_UNLOCKED: begin
        if (w_fwd_ev) begin
          w_run_nxt = w_run_inc[7:0];
          if (w_run_inc == 9'(LOCK_CNT)) w_state_nxt = ST_LOCKED;
        end else if (w_ill_ev) begin
          w_run_nxt = '0;
        end
      end
      ST_LOCKED: begin
        if (w_ill_ev) begin
          w_state_nxt = ST_UNLOCKED;
          w_run_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = ST_UNLOCKED;
        w_run_nxt   = '0;
      end
    endcase
  end

  assign bin_out    = r_bin_p1;
  assign bin_valid  = r_bin_valid_p1;
  assign wrap_pulse = r_wrap_p1;
  assign step_err   = r_step_err_p1;
  assign err_count  = r_err_count;
  assign locked     = (r_state == ST_LOCKED);

endmodule

// File: tb/tb_lo_gray_decoder.sv
module tb_lo_gray_decoder;
  localparam int S    = 2;
  localparam int LOCK = 16;

  logic       clk = 1'b0;
  logic       rstb = 1'b0;
  logic       en = 1'b0;
  logic [7:0] gray_in = 8'hFF;

  logic [7:0] bin_out;
  logic       bin_valid, wrap_pulse, step_err, locked;
  logic [7:0] err_count;
  logic [7:0] s_bin_out;
  logic       s_bin_valid, s_wrap_pulse, s_step_err, s_locked;
  logic [1:0] s_err_count;

  lo_gray_decoder #(.SYNC_STAGES(S), .LOCK_CNT(LOCK), .ERR_W(8)) u_dut (
    .clk(clk), .rstb(rstb), .en(en), .gray_in(gray_in),
    .bin_out(bin_out), .bin_valid(bin_valid), .wrap_pulse(wrap_pulse),
    .step_err(step_err), .err_count(err_count), .locked(locked));

  lo_gray_decoder #(.SYNC_STAGES(S), .LOCK_CNT(LOCK), .ERR_W(2)) u_sat (
    .clk(clk), .rstb(rstb), .en(en), .gray_in(gray_in),
    .bin_out(s_bin_out), .bin_valid(s_bin_valid), .wrap_pulse(s_wrap_pulse),
    .step_err(s_step_err), .err_count(s_err_count), .locked(s_locked));

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] bin;
    logic       bv;
    logic       wr;
    logic       se;
    logic [7:0] ec;
    logic [1:0] ec2;
    logic       lk;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   wraps    = 0;

  task automatic chk(input string name, input int act, input int req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // Reference model: decoded value from the gray history, rules applied directly.
  logic [7:0] m_hist[S];
  logic [7:0] m_prev, m_bin, m_ec, m_run;
  logic [1:0] m_ec2;
  logic       m_primed, m_locked;

  function automatic logic [7:0] g2b(input logic [7:0] g);
    logic [7:0] b;
    b = g;
    for (int s = 1; s < 8; s++) b = b ^ (g >> s);
    return b;
  endfunction

  initial begin
    exp_t e;
    logic [7:0] cur;
    forever begin
      @(posedge clk);
      e = '0;
      if (!rstb) begin
        for (int i = 0; i < S; i++) m_hist[i] = 8'd0;
        m_prev = 0; m_bin = 0; m_ec = 0; m_ec2 = 0; m_run = 0;
        m_primed = 0; m_locked = 0;
      end else begin
        cur = g2b(m_hist[S-1]);
        for (int i = S-1; i > 0; i--) m_hist[i] = m_hist[i-1];
        m_hist[0] = gray_in;
        if (!en) begin
          m_primed = 0;
        end else if (!m_primed) begin
          m_prev = cur; m_bin = cur; m_primed = 1;
        end else if (cur == m_prev) begin
        end else if (cur == 8'(m_prev + 1)) begin
          e.wr = (m_prev == 8'd255) && (cur == 8'd0);
          e.bv = 1;
          m_bin = cur; m_prev = cur;
          if (!m_locked) begin
            m_run = m_run + 1;
            if (int'(m_run) == LOCK) m_locked = 1;
          end
        end else begin
          e.se = 1;
          if (m_ec != 8'hFF) m_ec = m_ec + 1;
          if (m_ec2 != 2'd3) m_ec2 = m_ec2 + 1;
          m_prev = cur; m_bin = cur; m_run = 0; m_locked = 0;
        end
      end
      e.bin = m_bin; e.ec = m_ec; e.ec2 = m_ec2; e.lk = m_locked;
      exp_q.push_back(e);
    end
  end

  // Monitor: every cycle the DUT presents its registered outputs.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() == 0) begin
        chk("scoreboard_empty", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("bin_out", bin_out, e.bin);
        chk("bin_valid", bin_valid, e.bv);
        chk("wrap_pulse", wrap_pulse, e.wr);
        chk("step_err", step_err, e.se);
        chk("err_count", err_count, e.ec);
        chk("locked", locked, e.lk);
        chk("sat_err_count", s_err_count, e.ec2);
        chk("sat_locked", s_locked, e.lk);
        if (wrap_pulse === 1'b1) wraps++;
      end
    end
  end

  task automatic drive(input logic r, input logic e, input logic [7:0] b, input int n);
    rstb = r; en = e; gray_in = b ^ (b >> 1);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int w0;
    logic [7:0] b;
    int r, k;
    // T1 reset with gray_in = FF
    rstb = 0; en = 0; gray_in = 8'hFF;
    repeat (3) @(negedge clk);
    chk("t1_bin_out", bin_out, 0);
    chk("t1_locked", locked, 0);
    // T2 latency
    drive(1, 1, 8'd0, 6);
    drive(1, 1, 8'd1, 2);
    chk("t2_valid_early", bin_valid, 0);
    @(negedge clk);
    chk("t2_valid", bin_valid, 1);
    chk("t2_bin", bin_out, 1);
    @(negedge clk);
    chk("t2_valid_drop", bin_valid, 0);
    // T3 lock and wrap
    w0 = wraps;
    for (int v = 2; v <= 259; v++) drive(1, 1, 8'(v), 4);
    chk("t3_wrap_count", wraps - w0, 1);
    chk("t3_locked", locked, 1);
    chk("t3_err_count", err_count, 0);
    // T4 glitch while locked
    drive(1, 1, 8'd7, 4);
    chk("t4_err_count", err_count, 1);
    chk("t4_locked", locked, 0);
    drive(1, 1, 8'd8, 4);
    chk("t4_err_after", err_count, 1);
    // T5 saturation
    drive(1, 1, 8'd20, 4); drive(1, 1, 8'd40, 4); drive(1, 1, 8'd60, 4);
    drive(1, 1, 8'd80, 4); drive(1, 1, 8'd100, 4);
    chk("t5_sat", s_err_count, 3);
    chk("t5_full", err_count, 6);
    // T6 enable gap
    drive(1, 1, 8'd101, 4); drive(1, 1, 8'd102, 4);
    for (int v = 103; v <= 107; v++) drive(1, 0, 8'(v), 2);
    drive(1, 1, 8'd107, 4);
    chk("t6_no_err", err_count, 6);
    chk("t6_bin", bin_out, 107);
    drive(1, 1, 8'd108, 4);
    // Reset in the middle of operation
    drive(0, 1, 8'd108, 2);
    // Randomised phase
    b = 8'd108;
    for (int it = 0; it < 600; it++) begin
      r = $urandom_range(0, 99);
      k = $urandom_range(1, 4);
      if (r < 70) begin
        b = b + 1; drive(1, 1, b, k);
      end else if (r < 80) begin
        b = 8'($urandom); drive(1, 1, b, k);
      end else if (r < 90) begin
        b = b + 8'($urandom_range(0, 3)); drive(1, 0, b, k);
      end else if (r < 93) begin
        drive(0, 1, b, k);
      end else begin
        drive(1, 1, b, k);
      end
    end
    drive(1, 1, b, 4);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
